// File: rtl/ysyx_22041211_mem_arbiter.sv
// Memory port arbiter: the IFU (read-only) and the LSU (read/write) share a
// single memory port with one transaction in flight. The LSU wins by default;
// a streak counter forces the IFU in after MAX_LSU_STREAK consecutive LSU
// grants while the IFU was waiting. A response watchdog turns a lost memory
// response into an error response for the owner of the transaction.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; one requester may be accepted this cycle
// REQ   | request presented on mem_req_*, waiting for mem_req_ready
// RSP   | request taken by memory, waiting for mem_rsp_valid or timeout
module ysyx_22041211_mem_arbiter #(
    parameter int  ADDR_LEN       = 32,
    parameter int  DATA_LEN       = 32,
    parameter int  MAX_LSU_STREAK = 4,
    parameter int  TIMEOUT        = 255,
    localparam int STRB_W         = DATA_LEN / 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_LEN-1:0] ifu_rsp_data,
    output logic                ifu_rsp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_LEN-1:0] lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_LEN-1:0] lsu_req_wdata,
    input  logic [STRB_W-1:0]   lsu_req_wstrb,
    output logic                lsu_rsp_valid,
    output logic [DATA_LEN-1:0] lsu_rsp_data,
    output logic                lsu_rsp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_LEN-1:0] mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_LEN-1:0] mem_req_wdata,
    output logic [STRB_W-1:0]   mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_LEN-1:0] mem_rsp_data,
    input  logic                mem_rsp_err,

    output logic                owner
);

    localparam int STREAK_W = $clog2(MAX_LSU_STREAK + 1);
    // watchdog counts RSP cycles 0..TIMEOUT-1 and fires on the last one
    localparam int WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    logic                  in_idle;
    logic                  grant_ifu;

    logic                  mem_req_valid_d;
    logic [ADDR_LEN-1:0]   mem_req_addr_d;
    logic                  mem_req_wen_d;
    logic [DATA_LEN-1:0]   mem_req_wdata_d;
    logic [STRB_W-1:0]     mem_req_wstrb_d;
    logic                  owner_d;

    logic                  rsp_fire;
    logic                  rsp_err_n;
    logic [DATA_LEN-1:0]   rsp_data_n;

    logic                  ifu_rsp_valid_d;
    logic [DATA_LEN-1:0]   ifu_rsp_data_d;
    logic                  ifu_rsp_err_d;
    logic                  lsu_rsp_valid_d;
    logic [DATA_LEN-1:0]   lsu_rsp_data_d;
    logic                  lsu_rsp_err_d;

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign in_idle       = rst && (state_q == S_IDLE);
    assign grant_ifu     = ifu_req_valid && (!lsu_req_valid || (streak_q == STREAK_MAX));
    assign ifu_req_ready = in_idle && grant_ifu;
    assign lsu_req_ready = in_idle && lsu_req_valid && !grant_ifu;

    // Next-state, next registered outputs, streak and watchdog.
    always_comb begin
        state_d         = state_q;
        streak_d        = streak_q;
        wd_d            = wd_q;
        mem_req_valid_d = mem_req_valid;
        mem_req_addr_d  = mem_req_addr;
        mem_req_wen_d   = mem_req_wen;
        mem_req_wdata_d = mem_req_wdata;
        mem_req_wstrb_d = mem_req_wstrb;
        owner_d         = owner;
        rsp_fire        = 1'b0;
        rsp_err_n       = 1'b0;
        rsp_data_n      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (ifu_req_ready) begin
                    state_d         = S_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = ifu_req_addr;
                    mem_req_wen_d   = 1'b0;
                    mem_req_wdata_d = '0;
                    mem_req_wstrb_d = '0;
                    owner_d         = 1'b0;
                end else if (lsu_req_ready) begin
                    state_d         = S_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = lsu_req_addr;
                    mem_req_wen_d   = lsu_req_wen;
                    mem_req_wdata_d = lsu_req_wen ? lsu_req_wdata : '0;
                    mem_req_wstrb_d = lsu_req_wen ? lsu_req_wstrb : '0;
                    owner_d         = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d         = S_RSP;
                    mem_req_valid_d = 1'b0;
                    wd_d            = '0;
                end
            end
            S_RSP: begin
                // a real response on the timeout cycle still wins
                if (mem_rsp_valid) begin
                    rsp_fire   = 1'b1;
                    rsp_err_n  = mem_rsp_err;
                    rsp_data_n = mem_req_wen ? '0 : mem_rsp_data;
                    state_d    = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    rsp_fire   = 1'b1;
                    rsp_err_n  = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wd_d       = wd_q + WD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!ifu_req_valid || ifu_req_ready) begin
            streak_d = '0;
        end else if (lsu_req_ready && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        ifu_rsp_valid_d = rsp_fire && !owner;
        ifu_rsp_data_d  = (rsp_fire && !owner) ? rsp_data_n : '0;
        ifu_rsp_err_d   = rsp_fire && !owner && rsp_err_n;
        lsu_rsp_valid_d = rsp_fire && owner;
        lsu_rsp_data_d  = (rsp_fire && owner) ? rsp_data_n : '0;
        lsu_rsp_err_d   = rsp_fire && owner && rsp_err_n;
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            streak_q      <= '0;
            wd_q          <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            owner         <= 1'b0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_data  <= '0;
            ifu_rsp_err   <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
            lsu_rsp_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            wd_q          <= wd_d;
            mem_req_valid <= mem_req_valid_d;
            mem_req_addr  <= mem_req_addr_d;
            mem_req_wen   <= mem_req_wen_d;
            mem_req_wdata <= mem_req_wdata_d;
            mem_req_wstrb <= mem_req_wstrb_d;
            owner         <= owner_d;
            ifu_rsp_valid <= ifu_rsp_valid_d;
            ifu_rsp_data  <= ifu_rsp_data_d;
            ifu_rsp_err   <= ifu_rsp_err_d;
            lsu_rsp_valid <= lsu_rsp_valid_d;
            lsu_rsp_data  <= lsu_rsp_data_d;
            lsu_rsp_err   <= lsu_rsp_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Bench for the memory arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of the grant
// rule, request fields and response timing.
module tb_ysyx_22041211_mem_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        lsu_rsp_err;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        owner;

    ysyx_22041211_mem_arbiter #(
        .ADDR_LEN       (32),
        .DATA_LEN       (32),
        .MAX_LSU_STREAK (MAX_STREAK),
        .TIMEOUT        (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wstrb (lsu_req_wstrb),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .lsu_rsp_err   (lsu_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .owner         (owner)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: pending requests and the LSU streak seen by a waiting IFU
    logic        m_ifu_pend = 1'b0;
    logic [31:0] m_ifu_addr = '0;
    logic        m_lsu_pend = 1'b0;
    logic [31:0] m_lsu_addr = '0;
    logic        m_lsu_wen  = 1'b0;
    logic [31:0] m_lsu_wdata = '0;
    logic [3:0]  m_lsu_wstrb = '0;
    int          m_streak   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic new_lsu(input logic wen);
        m_lsu_pend  = 1'b1;
        m_lsu_addr  = $urandom;
        m_lsu_wen   = wen;
        m_lsu_wdata = $urandom;
        m_lsu_wstrb = 4'($urandom_range(0, 15));
    endtask

    // One full transaction starting in an IDLE cycle; returns in the
    // response-pulse cycle, which is also the next IDLE cycle.
    task automatic do_txn(input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                          input logic rerr, output logic got_lsu);
        logic        exp_lsu;
        logic [31:0] e_addr, e_wdata, e_data;
        logic        e_wen, e_err, done;
        logic [3:0]  e_strb;
        int          k;

        ifu_req_valid = m_ifu_pend;
        ifu_req_addr  = m_ifu_addr;
        lsu_req_valid = m_lsu_pend;
        lsu_req_addr  = m_lsu_addr;
        lsu_req_wen   = m_lsu_wen;
        lsu_req_wdata = m_lsu_wdata;
        lsu_req_wstrb = m_lsu_wstrb;
        #1;
        exp_lsu = m_lsu_pend && !(m_ifu_pend && (m_streak == MAX_STREAK));
        chk_eq("ifu_ready", 64'(ifu_req_ready), 64'(m_ifu_pend && !exp_lsu));
        chk_eq("lsu_ready", 64'(lsu_req_ready), 64'(exp_lsu));
        got_lsu = lsu_req_ready;

        if (exp_lsu) begin
            e_addr  = m_lsu_addr;
            e_wen   = m_lsu_wen;
            e_wdata = m_lsu_wdata;
            e_strb  = m_lsu_wen ? m_lsu_wstrb : 4'h0;
            m_streak = !m_ifu_pend ? 0 : ((m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK);
            m_lsu_pend = 1'b0;
        end else begin
            e_addr  = m_ifu_addr;
            e_wen   = 1'b0;
            e_wdata = '0;
            e_strb  = 4'h0;
            m_streak = 0;
            m_ifu_pend = 1'b0;
        end

        tick;
        ifu_req_valid = m_ifu_pend;
        lsu_req_valid = m_lsu_pend;
        chk_eq("req_valid", 64'(mem_req_valid), 64'(1));
        chk_eq("req_addr", 64'(mem_req_addr), 64'(e_addr));
        chk_eq("req_wen", 64'(mem_req_wen), 64'(e_wen));
        chk_eq("req_wstrb", 64'(mem_req_wstrb), 64'(e_strb));
        if (e_wen) chk_eq("req_wdata", 64'(mem_req_wdata), 64'(e_wdata));
        chk_eq("owner", 64'(owner), 64'(exp_lsu));
        chk_eq("rsp_single_pulse", 64'(ifu_rsp_valid | lsu_rsp_valid), 64'(0));

        for (int i = 0; i < rdy_dly; i++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'($urandom_range(0, 1));
            tick;
            chk_eq("req_hold_valid", 64'(mem_req_valid), 64'(1));
            chk_eq("req_hold_addr", 64'(mem_req_addr), 64'(e_addr));
        end
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'($urandom_range(0, 1));
        tick;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        chk_eq("req_dropped", 64'(mem_req_valid), 64'(0));

        k      = 1;
        done   = 1'b0;
        e_err  = 1'b0;
        e_data = '0;
        while (!done) begin
            mem_rsp_data = $urandom;
            if ((rsp_dly < TIMEOUT) && (k == rsp_dly + 1)) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = rdata;
                mem_rsp_err   = rerr;
                tick;
                mem_rsp_valid = 1'b0;
                mem_rsp_err   = 1'b0;
                e_err  = rerr;
                e_data = e_wen ? 32'h0 : rdata;
                done   = 1'b1;
            end else begin
                tick;
                if (k == TIMEOUT) begin
                    e_err  = 1'b1;
                    e_data = 32'h0;
                    done   = 1'b1;
                end else begin
                    chk_eq("no_early_rsp", 64'(ifu_rsp_valid | lsu_rsp_valid), 64'(0));
                end
            end
            k++;
        end

        if (exp_lsu) begin
            chk_eq("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(1));
            chk_eq("lsu_rsp_data", 64'(lsu_rsp_data), 64'(e_data));
            chk_eq("lsu_rsp_err", 64'(lsu_rsp_err), 64'(e_err));
            chk_eq("ifu_no_rsp", 64'(ifu_rsp_valid), 64'(0));
        end else begin
            chk_eq("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(1));
            chk_eq("ifu_rsp_data", 64'(ifu_rsp_data), 64'(e_data));
            chk_eq("ifu_rsp_err", 64'(ifu_rsp_err), 64'(e_err));
            chk_eq("lsu_no_rsp", 64'(lsu_rsp_valid), 64'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, got no summary, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       g;
        logic [5:0] pat;
        logic [5:0] exp_pat;
        int         rsp_dly;

        // reset with every valid asserted
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h1234;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h5678;
        lsu_req_wen = 1'b1; lsu_req_wdata = 32'hffff_ffff; lsu_req_wstrb = 4'hf;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hffff_ffff; mem_rsp_err = 1'b1;
        tick;
        tick;
        chk_eq("rst_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
        chk_eq("rst_req", 64'({mem_req_valid, mem_req_wen, mem_req_wstrb, owner}), 64'(0));
        chk_eq("rst_req_addr", 64'({mem_req_addr, mem_req_wdata}), 64'(0));
        chk_eq("rst_rsp", 64'({ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err}), 64'(0));
        chk_eq("rst_rsp_data", 64'({ifu_rsp_data, lsu_rsp_data}), 64'(0));
        rst = 1'b1;
        #1;
        chk_eq("post_rst_lsu_ready", 64'(lsu_req_ready), 64'(1));
        chk_eq("post_rst_ifu_ready", 64'(ifu_req_ready), 64'(0));
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        tick;

        // IFU fetch
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0000;
        do_txn(0, 0, 32'h0010_0093, 1'b0, g);

        // LSU store then load
        m_lsu_pend = 1'b1; m_lsu_addr = 32'h8000_1000; m_lsu_wen = 1'b1;
        m_lsu_wdata = 32'hdead_beef; m_lsu_wstrb = 4'b0011;
        do_txn(1, 2, 32'h1234_5678, 1'b0, g);
        m_lsu_pend = 1'b1; m_lsu_addr = 32'h8000_1004; m_lsu_wen = 1'b0;
        m_lsu_wdata = 32'hcafe_f00d; m_lsu_wstrb = 4'hf;
        do_txn(0, 1, 32'ha5a5_0001, 1'b0, g);

        // IFU waiting while LSU keeps requesting: L,L,L,L,I,L
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0040;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            if (!m_lsu_pend) new_lsu(1'b0);
            do_txn(0, 0, $urandom, 1'b0, g);
            pat[i] = g;
        end
        exp_pat = 6'b101111;
        chk_eq("streak_pattern", 64'(pat), 64'(exp_pat));

        // watchdog: lost response, then response on the last cycle, then normal
        new_lsu(1'b0);
        do_txn(0, TIMEOUT, 32'h1111_2222, 1'b0, g);
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0080;
        do_txn(0, TIMEOUT - 1, 32'h3333_4444, 1'b0, g);
        new_lsu(1'b1);
        do_txn(2, 0, 32'h5555_6666, 1'b1, g);

        // reset while in RSP, then a late and a stray response
        m_lsu_pend = 1'b0; m_ifu_pend = 1'b0;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1'b0;
        #1;
        chk_eq("rsp_rst_accept", 64'(lsu_req_ready), 64'(1));
        tick;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        chk_eq("rsp_rst_outputs", 64'({mem_req_valid, owner, lsu_rsp_valid, ifu_rsp_valid}), 64'(0));
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_8888;
        tick;
        mem_rsp_valid = 1'b0;
        chk_eq("late_rsp_ignored", 64'({lsu_rsp_valid, ifu_rsp_valid, mem_req_valid}), 64'(0));
        mem_rsp_valid = 1'b1;
        tick;
        mem_rsp_valid = 1'b0;
        chk_eq("stray_rsp_ignored", 64'({lsu_rsp_valid, ifu_rsp_valid, mem_req_valid}), 64'(0));
        m_streak = 0;
        new_lsu(1'b0);
        do_txn(0, 0, 32'h9999_aaaa, 1'b0, g);

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            if (!m_ifu_pend && ($urandom_range(0, 2) != 0)) begin
                m_ifu_pend = 1'b1;
                m_ifu_addr = $urandom;
            end
            if (!m_lsu_pend && ($urandom_range(0, 3) != 0)) new_lsu(1'($urandom_range(0, 1)));
            if (!m_ifu_pend && !m_lsu_pend) new_lsu(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) rsp_dly = TIMEOUT + int'($urandom_range(0, 2));
            else rsp_dly = int'($urandom_range(0, TIMEOUT - 1));
            do_txn(int'($urandom_range(0, 3)), rsp_dly, $urandom, ($urandom_range(0, 7) == 0), g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
